uart_tx_scheduler: RTL and testbench

Shares one byte-wide UART transmit serializer among NUM_REQ independent requesters. Round-robin arbitration selects one byte, which is presented to the serializer with a one-cycle send strobe. The block then tracks the serializer's busy flag through the frame and enforces an inter-frame gap. It sits between the application producers (key/LED/status reporters) and the serializer that drives txd.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_picker.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 157 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and default constants for the UART TX scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam int c_DEF_NUM_REQ      = 4;
    localparam int c_DEF_DATA_W       = 8;
    localparam int c_DEF_GAP_CYCLES   = 2;
    localparam int c_DEF_BUSY_TIMEOUT = 16;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Combinational round-robin picker; first request above the pointer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_winner
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan from farthest to nearest so the candidate right after the pointer
    // is the last one written and therefore wins.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[ID_W-1:0];
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule : rr_picker

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Round-robin sharing of one UART TX serializer among NUM_REQ sources.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = c_DEF_NUM_REQ,
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int GAP_CYCLES   = c_DEF_GAP_CYCLES,
    parameter int BUSY_TIMEOUT = c_DEF_BUSY_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_send,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic                        err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              r_state,    w_state_nxt;
    logic [ID_W-1:0]     r_ptr,      w_ptr_nxt;
    logic [TO_W-1:0]     r_to_cnt,   w_to_cnt_nxt;
    logic [GAP_W-1:0]    r_gap_cnt,  w_gap_cnt_nxt;
    logic [NUM_REQ-1:0]  r_ack,      w_ack_nxt;
    logic                r_send,     w_send_nxt;
    logic [DATA_W-1:0]   r_data,     w_data_nxt;
    logic [ID_W-1:0]     r_gid,      w_gid_nxt;
    logic                r_active,   w_active_nxt;
    logic                r_err,      w_err_nxt;

    logic                w_valid;
    logic [ID_W-1:0]     w_winner;
    logic [TO_W-1:0]     w_to_inc;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner)
    );

    assign w_to_inc = r_to_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= ID_W'(NUM_REQ - 1);
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_ack     <= '0;
            r_send    <= 1'b0;
            r_data    <= '0;
            r_gid     <= '0;
            r_active  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_ack     <= w_ack_nxt;
            r_send    <= w_send_nxt;
            r_data    <= w_data_nxt;
            r_gid     <= w_gid_nxt;
            r_active  <= w_active_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_to_cnt_nxt  = r_to_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_ack_nxt     = '0;
        w_send_nxt    = 1'b0;
        w_data_nxt    = r_data;
        w_gid_nxt     = r_gid;
        w_err_nxt     = r_err;

        case (r_state)
            IDLE: begin
                if (!tx_busy && w_valid) begin
                    w_data_nxt          = req_data[w_winner*DATA_W +: DATA_W];
                    w_gid_nxt           = w_winner;
                    w_ack_nxt[w_winner] = 1'b1;
                    w_send_nxt          = 1'b1;
                    w_ptr_nxt           = w_winner;
                    w_state_nxt         = LAUNCH;
                end
            end
            LAUNCH: begin
                w_to_cnt_nxt = '0;
                w_state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Timeout lands exactly BUSY_TIMEOUT cycles after the strobe.
                if (tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_to_inc >= c_TO_LAST) begin
                    w_err_nxt     = 1'b1;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    w_to_cnt_nxt = w_to_inc;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap_cnt >= c_GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_active_nxt = (w_state_nxt != IDLE);
    end

    assign ack      = r_ack;
    assign tx_send  = r_send;
    assign tx_data  = r_data;
    assign grant_id = r_gid;
    assign active   = r_active;
    assign err      = r_err;

endmodule : uart_tx_scheduler

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module : tb_uart_tx_scheduler
// Brief  : Directed vector table plus hand sequences for uart_tx_scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int GAPC = 2;
    localparam int BTO  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0] ack;
    logic            tx_send;
    logic [DW-1:0]   tx_data;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            active;
    logic            err;

    int n_checks = 0;
    int n_errors = 0;

    bit model_en = 1'b0;
    int busy_len = 4;
    int busy_cnt = 0;

    uart_tx_scheduler #(
        .NUM_REQ      (NREQ),
        .DATA_W       (DW),
        .GAP_CYCLES   (GAPC),
        .BUSY_TIMEOUT (BTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*DW-1:0] data;
        logic               busy;
        logic [NREQ-1:0]    e_ack;
        logic               e_send;
        logic [DW-1:0]      e_data;
        logic [1:0]         e_gid;
        logic               e_active;
        logic               e_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; inputs change and outputs are observed at the falling edge.
    // The serializer model starts a busy window when it sees the strobe.
    task automatic cycle();
        @(negedge clk);
        if (model_en) begin
            if (tx_send) begin
                chk("no_send_while_busy", 32'(tx_busy), 32'd0);
                busy_cnt = busy_len;
            end
            tx_busy = (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        model_en = 1'b0;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        req      = '0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_send(input string name);
        int k;
        k = 0;
        while (!tx_send && k < 40) begin
            cycle();
            k++;
        end
        chk(name, 32'(tx_send), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_idx;
        int sends;
        bit prev_ack;
        int exp_order[3];

        vecs[0] = '{4'b0010, 32'h0000_4100, 1'b0, 4'b0010, 1'b1, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[1] = '{4'b0000, 32'h0000_4100, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 32'h0000_4100, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[3] = '{4'b0000, 32'h0000_4100, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{4'b0000, 32'h0000_4100, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 32'h0000_4100, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b1, 1'b0};
        vecs[6] = '{4'b0000, 32'h0000_4100, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b0, 1'b0};
        vecs[7] = '{4'b0001, 32'h0000_0055, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd1, 1'b0, 1'b0};
        vecs[8] = '{4'b0001, 32'h0000_0055, 1'b0, 4'b0001, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0};

        // Reset state
        do_reset();
        chk("rst_ack",    32'(ack),      32'd0);
        chk("rst_send",   32'(tx_send),  32'd0);
        chk("rst_data",   32'(tx_data),  32'd0);
        chk("rst_gid",    32'(grant_id), 32'd0);
        chk("rst_active", 32'(active),   32'd0);
        chk("rst_err",    32'(err),      32'd0);

        // Vector table: single request, frame, gap, busy-in-idle hold-off
        for (int v = 0; v < 9; v++) begin
            req      = vecs[v].req;
            req_data = vecs[v].data;
            tx_busy  = vecs[v].busy;
            cycle();
            chk($sformatf("vec%0d_ack", v),    32'(ack),      32'(vecs[v].e_ack));
            chk($sformatf("vec%0d_send", v),   32'(tx_send),  32'(vecs[v].e_send));
            chk($sformatf("vec%0d_data", v),   32'(tx_data),  32'(vecs[v].e_data));
            chk($sformatf("vec%0d_gid", v),    32'(grant_id), 32'(vecs[v].e_gid));
            chk($sformatf("vec%0d_active", v), 32'(active),   32'(vecs[v].e_active));
            chk($sformatf("vec%0d_err", v),    32'(err),      32'(vecs[v].e_err));
        end

        // All four requesting continuously: order 30,31,32,33,30
        do_reset();
        model_en = 1'b1;
        busy_len = 4;
        req_data = 32'h3332_3130;
        req      = 4'b1111;
        exp_idx  = 0;
        sends    = 0;
        prev_ack = 1'b0;
        for (int c = 0; c < 300 && sends < 5; c++) begin
            cycle();
            if (prev_ack) chk("rr_ack_one_cycle", 32'(ack), 32'd0);
            prev_ack = (ack != '0);
            if (tx_send) begin
                chk("rr_data", 32'(tx_data), 32'(8'h30 + exp_idx));
                chk("rr_ack",  32'(ack),     32'(1 << exp_idx));
                exp_idx = (exp_idx + 1) % NREQ;
                sends++;
            end
        end
        chk("rr_sends", 32'(sends), 32'd5);

        // Fairness after reset: req0 and req3, req0 re-requests -> 0,3,0
        do_reset();
        model_en     = 1'b1;
        busy_len     = 3;
        req_data     = 32'hA300_00A0;
        req          = 4'b1001;
        exp_order[0] = 0;
        exp_order[1] = 3;
        exp_order[2] = 0;
        sends        = 0;
        for (int c = 0; c < 300 && sends < 3; c++) begin
            cycle();
            if (tx_send) begin
                chk("fair_gid", 32'(grant_id), 32'(exp_order[sends]));
                if (ack[3]) req[3] = 1'b0;
                sends++;
            end
        end
        chk("fair_sends", 32'(sends), 32'd3);

        // Serializer already busy in IDLE for 5 cycles
        do_reset();
        tx_busy  = 1'b1;
        req_data = 32'h0000_00C5;
        req      = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("busy_hold_ack",  32'(ack),     32'd0);
            chk("busy_hold_send", 32'(tx_send), 32'd0);
        end
        tx_busy = 1'b0;
        cycle();
        chk("busy_release_ack",  32'(ack),     32'b0001);
        chk("busy_release_send", 32'(tx_send), 32'd1);
        chk("busy_release_data", 32'(tx_data), 32'hC5);

        // Stuck serializer: err exactly BTO cycles after strobe
        do_reset();
        tx_busy  = 1'b0;
        req_data = 32'h0077_0000;
        req      = 4'b0100;
        wait_send("stuck_send");
        req = '0;
        chk("stuck_data", 32'(tx_data), 32'h77);
        for (int k = 1; k <= BTO; k++) begin
            cycle();
            if (k == BTO - 1) chk("stuck_err_early", 32'(err), 32'd0);
            if (k == BTO) begin
                chk("stuck_err",    32'(err),    32'd1);
                chk("stuck_in_gap", 32'(active), 32'd1);
            end
        end
        cycle();
        cycle();
        chk("stuck_idle", 32'(active), 32'd0);
        req_data = 32'h0000_0011;
        req      = 4'b0001;
        cycle();
        chk("stuck_regrant_ack", 32'(ack), 32'b0001);
        chk("stuck_err_sticky",  32'(err), 32'd1);

        // Reset during WAIT_DONE
        do_reset();
        model_en = 1'b1;
        busy_len = 10;
        req_data = 32'h0000_9900;
        req      = 4'b0010;
        wait_send("mid_send");
        req = '0;
        for (int c = 0; c < 4; c++) cycle();
        chk("mid_active", 32'(active), 32'd1);
        rst      = 1'b1;
        model_en = 1'b0;
        busy_cnt = 0;
        tx_busy  = 1'b0;
        req_data = 32'h4443_4241;
        req      = 4'b1111;
        cycle();
        chk("mid_rst_ack",    32'(ack),      32'd0);
        chk("mid_rst_send",   32'(tx_send),  32'd0);
        chk("mid_rst_data",   32'(tx_data),  32'd0);
        chk("mid_rst_gid",    32'(grant_id), 32'd0);
        chk("mid_rst_active", 32'(active),   32'd0);
        rst = 1'b0;
        cycle();
        chk("mid_first_ack",  32'(ack),     32'b0001);
        chk("mid_first_data", 32'(tx_data), 32'h41);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_scheduler

`default_nettype wire
